// File: rtl/luna_pkg.sv
// Shared types and constants for the boot-time program loader.
// Holds the loader state encoding, frame sync byte and default ROM address width.
package luna_pkg;

  localparam int unsigned DEF_ADDR_W = 15;
  localparam logic [7:0]  SYNC_BYTE  = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StCntHi,
    StCntLo,
    StDataHi,
    StDataLo,
    StCheck,
    StDone,
    StErr
  } loader_state_e;

  // States in which an inter-byte stall is bounded by the idle timer.
  function automatic logic is_frame_state(loader_state_e s);
    return s inside {StCntHi, StCntLo, StDataHi, StDataLo, StCheck};
  endfunction

endpackage

// File: rtl/loader_timer.sv
// Idle-cycle counter for the loader: counts cycles without a byte transfer while
// enabled and flags expiry on the cycle the count would reach TIMEOUT.
module loader_timer #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int unsigned    CntW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // A transfer in the limit cycle wins, so clear masks expiry.
  assign expire = enable && !clear && (cnt_q == Limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable || expire) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: parses SYNC/count/data/checksum frames, writes 16-bit
// words to the instruction ROM and releases the CPU reset only after a good checksum.
module prog_loader
  import luna_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int unsigned MaxWords = 32'd1 << ADDR_W;

  loader_state_e state_q, state_d;

  logic [7:0]        sum_q;
  logic [7:0]        cnt_hi_q;
  logic [15:0]       n_q;
  logic [ADDR_W:0]   word_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        hi_q;

  logic              rx_ready_q, rx_ready_d;
  logic              rom_we_q, rom_we_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [15:0]       rom_wdata_q, rom_wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic        xfer;
  logic        sync_ok;
  logic        expire;
  logic [15:0] n_next;
  logic        last_word;

  assign xfer      = rx_valid & rx_ready_q;
  assign sync_ok   = xfer && (state_q == StIdle || state_q == StDone) && (rx_data == SYNC_BYTE);
  assign n_next    = {cnt_hi_q, rx_data};
  assign last_word = (32'(word_cnt_q) + 32'd1) == 32'(n_q);

  loader_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (is_frame_state(state_q)),
    .clear  (xfer),
    .expire (expire)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (sync_ok) state_d = StCntHi;
      StCntHi:        if (xfer) state_d = StCntLo;
      StCntLo: begin
        if (xfer) begin
          if (32'(n_next) > MaxWords) begin
            state_d = StErr;
          end else if (n_next == 16'd0) begin
            state_d = StCheck;
          end else begin
            state_d = StDataHi;
          end
        end
      end
      StDataHi:       if (xfer) state_d = StDataLo;
      StDataLo:       if (xfer) state_d = last_word ? StCheck : StDataHi;
      StCheck:        if (xfer) state_d = (rx_data == sum_q) ? StDone : StErr;
      StErr:          state_d = StIdle;
      default:        state_d = StIdle;
    endcase
    if (expire) begin
      state_d = StErr;
    end
  end

  // Registered-output next values
  always_comb begin
    rx_ready_d  = 1'b1;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    cpu_rst_d   = cpu_rst_q;
    done_d      = done_q;
    err_d       = err_q;
    if (xfer && state_q == StDataLo) begin
      rom_we_d    = 1'b1;
      rom_addr_d  = addr_q;
      rom_wdata_d = {hi_q, rx_data};
    end
    if (sync_ok) begin
      cpu_rst_d = 1'b1;
      done_d    = 1'b0;
      err_d     = 1'b0;
    end
    if (state_q == StCheck && state_d == StDone) begin
      cpu_rst_d = 1'b0;
      done_d    = 1'b1;
      err_d     = 1'b0;
    end
    if (state_d == StErr) begin
      cpu_rst_d = 1'b1;
      done_d    = 1'b0;
      err_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ready_q  <= 1'b0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rx_ready_q  <= rx_ready_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      cpu_rst_q   <= cpu_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Checksum, count and word assembly; the ROM is written ahead of verification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q      <= '0;
      cnt_hi_q   <= '0;
      n_q        <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      hi_q       <= '0;
    end else if (xfer) begin
      unique case (state_q)
        StIdle, StDone: begin
          if (rx_data == SYNC_BYTE) begin
            sum_q      <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
          end
        end
        StCntHi: begin
          cnt_hi_q <= rx_data;
          sum_q    <= sum_q + rx_data;
        end
        StCntLo: begin
          n_q   <= n_next;
          sum_q <= sum_q + rx_data;
        end
        StDataHi: begin
          hi_q  <= rx_data;
          sum_q <= sum_q + rx_data;
        end
        StDataLo: begin
          sum_q      <= sum_q + rx_data;
          addr_q     <= addr_q + ADDR_W'(1);
          word_cnt_q <= word_cnt_q + (ADDR_W + 1)'(1);
        end
        default: ;
      endcase
    end
  end

  assign rx_ready  = rx_ready_q;
  assign rom_we    = rom_we_q;
  assign rom_addr  = rom_addr_q;
  assign rom_wdata = rom_wdata_q;
  assign cpu_rst   = cpu_rst_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus randomized frames with
// stalls, checked against a byte-level frame-protocol model.
module tb_prog_loader;

  localparam int unsigned AW = 4;
  localparam int unsigned TO = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          rom_we;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  prog_loader #(
    .ADDR_W  (AW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Protocol model state
  bit         m_in_frame = 0;
  bit         m_drop_next = 0;
  int         m_pos, m_n, m_addr;
  logic [7:0] m_nhi, m_hi, m_sum;
  bit         m_done = 0, m_err = 0, m_cpu_rst = 1;
  int         idle_run = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [7:0]  frm_b[$];
  int          frm_g[$];

  always @(negedge clk) begin
    if (rom_we) got_q.push_back((32'(rom_addr) << 16) | 32'(rom_wdata));
  end

  function automatic void model_fail();
    m_err = 1; m_done = 0; m_cpu_rst = 1;
  endfunction

  function automatic void model_reset();
    m_in_frame = 0; m_drop_next = 0; m_done = 0; m_err = 0; m_cpu_rst = 1;
  endfunction

  // g = idle cycles since the previous transfer
  function automatic void model_byte(input logic [7:0] b, input int g);
    bit drop;
    drop = m_drop_next && (g == 0);
    m_drop_next = 0;
    if (m_in_frame && g >= int'(TO)) begin
      m_in_frame = 0;
      model_fail();
      if (g == int'(TO)) return;
    end else if (drop) begin
      return;
    end
    if (!m_in_frame) begin
      if (b == 8'hA5) begin
        m_in_frame = 1; m_pos = 0; m_sum = 0; m_addr = 0;
        m_done = 0; m_err = 0; m_cpu_rst = 1;
      end
      return;
    end
    if (m_pos == 0) begin
      m_nhi = b; m_sum += b;
    end else if (m_pos == 1) begin
      m_n = int'({m_nhi, b}); m_sum += b;
      if (m_n > (1 << AW)) begin
        model_fail(); m_in_frame = 0; m_drop_next = 1;
        return;
      end
    end else if (m_pos < 2 + 2 * m_n) begin
      m_sum += b;
      if (m_pos % 2 == 0) begin
        m_hi = b;
      end else begin
        exp_q.push_back((32'(m_addr) << 16) | 32'({m_hi, b}));
        m_addr++;
      end
    end else begin
      if (b == m_sum) begin
        m_done = 1; m_err = 0; m_cpu_rst = 0;
      end else begin
        model_fail(); m_drop_next = 1;
      end
      m_in_frame = 0;
      return;
    end
    m_pos++;
  endfunction

  function automatic void model_settle();
    if (m_in_frame && idle_run >= int'(TO)) begin
      m_in_frame = 0;
      model_fail();
    end
    if (idle_run > 0) m_drop_next = 0;
  endfunction

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    idle_run += n;
    model_settle();
  endtask

  task automatic send_byte(input logic [7:0] b, input int g);
    if (g > 0) begin
      rx_valid = 1'b0;
      repeat (g) @(posedge clk);
      #1;
      idle_run += g;
    end
    model_byte(b, idle_run);
    idle_run = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < frm_b.size(); i++) send_byte(frm_b[i], frm_g[i]);
    frm_b.delete();
    frm_g.delete();
  endtask

  task automatic push_bytes(input logic [63:0] bytes, input int cnt);
    for (int i = cnt - 1; i >= 0; i--) begin
      frm_b.push_back(bytes[i*8 +: 8]);
      frm_g.push_back(0);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".done"}, 32'(done), 32'(m_done));
    check({tag, ".err"}, 32'(err), 32'(m_err));
    check({tag, ".cpu_rst"}, 32'(cpu_rst), 32'(m_cpu_rst));
    check({tag, ".rx_ready"}, 32'(rx_ready), 32'd1);
  endtask

  task automatic check_writes(input string tag);
    int n;
    check({tag, ".nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, ".wr"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, ".rom_we"}, 32'(rom_we), 32'd0);
    check({tag, ".rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, ".rom_wdata"}, 32'(rom_wdata), 32'd0);
    check({tag, ".cpu_rst"}, 32'(cpu_rst), 32'd1);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".err"}, 32'(err), 32'd0);
  endtask

  task automatic settle_and_check(input string tag);
    idle(TO + 2);
    check_outs(tag);
    check_writes(tag);
  endtask

  task automatic random_frame();
    int n, k;
    logic [7:0] s, b, chk;
    k = $urandom_range(0, 2);
    for (int i = 0; i < k; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h5A;
      frm_b.push_back(b);
      frm_g.push_back($urandom_range(0, 3));
    end
    n = ($urandom_range(0, 3) == 0) ? 16 : $urandom_range(0, 17);
    frm_b.push_back(8'hA5);
    frm_b.push_back(8'(n >> 8));
    frm_b.push_back(8'(n));
    s = 8'(n >> 8) + 8'(n);
    for (int i = 0; i < 2 * n; i++) begin
      b = 8'($urandom_range(0, 255));
      frm_b.push_back(b);
      s += b;
    end
    chk = ($urandom_range(0, 4) == 0) ? s ^ 8'($urandom_range(1, 255)) : s;
    frm_b.push_back(chk);
    frm_g.push_back($urandom_range(0, 3));
    while (frm_g.size() < frm_b.size()) begin
      frm_g.push_back(($urandom_range(0, 24) == 0) ? $urandom_range(TO, TO + 1)
                                                   : $urandom_range(0, 3));
    end
    send_frame();
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst.rx_ready_up", 32'(rx_ready), 32'd1);
    idle(TO + 2);

    // Good frame, back to back
    push_bytes(64'hA5_00_02_12_34_80_07, 7);
    send_frame();
    check("good.done_pre", 32'(done), 32'd0);
    send_byte(8'hCF, 0);
    check("good.done", 32'(done), 32'd1);
    check("good.cpu_rst", 32'(cpu_rst), 32'd0);
    check_outs("good");
    check("good.w0", exp_q[0], 32'h0000_1234);
    check("good.w1", exp_q[1], 32'h0001_8007);
    check_writes("good");

    // Bad checksum, then recovery
    push_bytes(64'hA5_00_02_12_34_80_07_CE, 8);
    send_frame();
    check("bad.err", 32'(err), 32'd1);
    check("bad.cpu_rst", 32'(cpu_rst), 32'd1);
    check_outs("bad");
    check_writes("bad");
    push_bytes(64'hA5_00_02_12_34_80_07_CF, 8);
    frm_g[0] = 1;
    send_frame();
    check_outs("recover");
    check_writes("recover");

    // Empty program
    push_bytes(64'hA5_00_00_00, 4);
    send_frame();
    check("empty.done", 32'(done), 32'd1);
    settle_and_check("empty");

    // Leading garbage
    push_bytes(64'h11_22, 2);
    push_bytes(64'hA5_00_02_12_34_80_07_CF, 8);
    send_frame();
    settle_and_check("garbage");

    // Oversize count
    push_bytes(64'hA5_00_11, 3);
    send_frame();
    check("over.err", 32'(err), 32'd1);
    settle_and_check("over");

    // Timeout: limit stall expires, one short of it does not
    push_bytes(64'hA5_00_01_12, 4);
    send_frame();
    idle(TO - 1);
    check("to.err_pre", 32'(err), 32'd0);
    idle(1);
    check("to.err", 32'(err), 32'd1);
    settle_and_check("to");
    push_bytes(64'hA5_00_01_12, 4);
    send_frame();
    send_byte(8'h34, TO - 1);
    send_byte(8'h47, TO - 1);
    check("to7.done", 32'(done), 32'd1);
    settle_and_check("to7");

    // Reset mid-frame
    push_bytes(64'hA5_00_02_12_34_80, 6);
    send_frame();
    check_writes("midrst.pre");
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    model_reset();
    #14 rst_n = 1'b1;
    @(posedge clk); #1;
    idle_run = 0;
    push_bytes(64'hA5_00_02_12_34_80_07_CF, 8);
    send_frame();
    settle_and_check("midrst.post");

    for (int i = 0; i < 30; i++) begin
      random_frame();
      settle_and_check("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
